// File: rtl/rvs_trace_capture_if.sv
// Trace read-out stream between rvs_trace_capture (master) and its consumer (slave).
// Handshake: a record transfers on a rising edge where rd_valid && rd_ready. While
// rd_valid is high and rd_ready is low, rd_data and rd_last hold steady.
interface rvs_trace_capture_if #(
    parameter int REC_W = 96
);
    logic             rd_valid;
    logic             rd_ready;
    logic [REC_W-1:0] rd_data;
    logic             rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/rvs_trace_capture.sv
// Windowed trace capture of reservation-station pointer/ready state into a circular buffer.
// Define RVS_TRACE_WRAP_EN to overwrite the oldest record on overflow instead of stopping.
module rvs_trace_capture #(
    parameter int NUM_CH    = 4,
    parameter int RVS_DEPTH = 4,
    parameter int BUF_DEPTH = 16,
    parameter int ORDER_W   = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arm,
    input  logic                          abort,
    input  logic [ORDER_W-1:0]            cfg_start_order,
    input  logic [ORDER_W-1:0]            cfg_end_order,
    input  logic [ORDER_W-1:0]            mon_order,
    input  logic [NUM_CH*$clog2(RVS_DEPTH)-1:0] rvs_wptr,
    input  logic [NUM_CH*$clog2(RVS_DEPTH)-1:0] rvs_rptr,
    input  logic [NUM_CH*RVS_DEPTH-1:0]   rvs_vld1,
    input  logic [NUM_CH*RVS_DEPTH-1:0]   rvs_vld2,
    rvs_trace_capture_if.master           rd,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(BUF_DEPTH):0]    rec_count,
    output logic [2:0]                    dbg_state
);
    localparam int PTR_W = $clog2(RVS_DEPTH);
    localparam int CH_W  = 2*PTR_W + 2*RVS_DEPTH;
    localparam int REC_W = 48 + NUM_CH*CH_W;
    localparam int AW    = $clog2(BUF_DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DONE    = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t           r_state;
    logic [REC_W-1:0] r_mem [BUF_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [15:0]      r_ts;
    logic             r_overflow;

    logic             w_ge_start;
    logic             w_ge_end;
    logic             w_in_window;
    logic             w_full;
    logic             w_store;
    logic             w_rd_valid;
    logic             w_pop;
    logic [REC_W-1:0] w_record;

    assign w_ge_start  = (mon_order >= cfg_start_order);
    assign w_ge_end    = (mon_order >= cfg_end_order);
    assign w_in_window = ((r_state == S_ARMED) || (r_state == S_CAPTURE)) && w_ge_start && !w_ge_end;
    assign w_full      = (r_count == FULL_CNT);
`ifdef RVS_TRACE_WRAP_EN
    assign w_store     = w_in_window && !abort;
`else
    assign w_store     = w_in_window && !abort && !w_full;
`endif
    assign w_rd_valid  = (r_state == S_DRAIN) && (r_count != '0);
    assign w_pop       = w_rd_valid && rd.rd_ready;

    // Record layout, MSB first: ts, order[31:0], then channels NUM_CH-1 .. 0.
    always_comb begin
        w_record = '0;
        w_record[REC_W-1 -: 16] = r_ts;
        w_record[REC_W-17 -: 32] = mon_order[31:0];
        for (int c = 0; c < NUM_CH; c++) begin
            w_record[c*CH_W +: CH_W] = {rvs_wptr[c*PTR_W +: PTR_W], rvs_rptr[c*PTR_W +: PTR_W],
                                        rvs_vld2[c*RVS_DEPTH +: RVS_DEPTH],
                                        rvs_vld1[c*RVS_DEPTH +: RVS_DEPTH]};
        end
    end

    // Storage array carries no reset; rd_data is masked while nothing is valid.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= w_record;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ts       <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_ts <= r_ts + 16'd1;
            if (abort) begin
                r_state  <= S_IDLE;
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (arm) begin
                            r_state    <= S_ARMED;
                            r_ts       <= '0;
                            r_overflow <= 1'b0;
                            r_wr_ptr   <= '0;
                            r_rd_ptr   <= '0;
                            r_count    <= '0;
                        end
                    end
                    S_ARMED, S_CAPTURE: begin
                        if (w_ge_end) begin
                            r_state <= S_DONE;
                        end else if (w_ge_start) begin
                            r_state <= S_CAPTURE;
                            if (!w_full) begin
                                r_wr_ptr <= r_wr_ptr + 1'b1;
                                r_count  <= r_count + ONE_CNT;
                            end else begin
                                r_overflow <= 1'b1;
`ifdef RVS_TRACE_WRAP_EN
                                r_wr_ptr   <= r_wr_ptr + 1'b1;
                                r_rd_ptr   <= r_rd_ptr + 1'b1;
`else
                                r_state    <= S_DONE;
`endif
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= (r_count == '0) ? S_IDLE : S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (w_pop) begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                            r_count  <= r_count - ONE_CNT;
                            if (r_count == ONE_CNT) begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign rd.rd_valid = w_rd_valid;
    assign rd.rd_data  = w_rd_valid ? r_mem[r_rd_ptr] : '0;
    assign rd.rd_last  = w_rd_valid && (r_count == ONE_CNT);
    assign busy        = (r_state != S_IDLE);
    assign overflow    = r_overflow;
    assign rec_count   = r_count;
    assign dbg_state   = r_state;
endmodule

// File: tb/tb_rvs_trace_capture.sv
// Directed bench for rvs_trace_capture: expected records queued at stimulus time,
// popped and compared by an independent monitor on the read stream.
module tb_rvs_trace_capture;
  localparam int NUM_CH    = 4;
  localparam int RVS_DEPTH = 4;
  localparam int PTR_W     = 2;
  localparam int BUF_DEPTH = 16;
  localparam int ORDER_W   = 64;
  localparam int CH_W      = 2*PTR_W + 2*RVS_DEPTH;
  localparam int REC_W     = 48 + NUM_CH*CH_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  logic                          clk;
  logic                          rst_n;
  logic                          arm;
  logic                          abort;
  logic [ORDER_W-1:0]            cfg_start_order;
  logic [ORDER_W-1:0]            cfg_end_order;
  logic [ORDER_W-1:0]            mon_order;
  logic [NUM_CH*PTR_W-1:0]       rvs_wptr;
  logic [NUM_CH*PTR_W-1:0]       rvs_rptr;
  logic [NUM_CH*RVS_DEPTH-1:0]   rvs_vld1;
  logic [NUM_CH*RVS_DEPTH-1:0]   rvs_vld2;
  logic                          busy;
  logic                          overflow;
  logic [$clog2(BUF_DEPTH):0]    rec_count;
  logic [2:0]                    dbg_state;

  rvs_trace_capture_if #(.REC_W(REC_W)) rd_bus ();

  rvs_trace_capture #(
    .NUM_CH(NUM_CH), .RVS_DEPTH(RVS_DEPTH), .BUF_DEPTH(BUF_DEPTH), .ORDER_W(ORDER_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .cfg_start_order(cfg_start_order), .cfg_end_order(cfg_end_order),
    .mon_order(mon_order), .rvs_wptr(rvs_wptr), .rvs_rptr(rvs_rptr),
    .rvs_vld1(rvs_vld1), .rvs_vld2(rvs_vld2), .rd(rd_bus),
    .busy(busy), .overflow(overflow), .rec_count(rec_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [REC_W:0] exp_q[$];  // {rd_last, record}
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gen_wptr(input logic [63:0] o);
    return o[7:0];
  endfunction
  function automatic logic [7:0] gen_rptr(input logic [63:0] o);
    return o[7:0] ^ 8'h5A;
  endfunction
  function automatic logic [15:0] gen_vld1(input logic [63:0] o);
    return o[15:0] * 16'd3;
  endfunction
  function automatic logic [15:0] gen_vld2(input logic [63:0] o);
    return ~o[15:0];
  endfunction

  function automatic logic [REC_W-1:0] pack_rec(input logic [15:0] ts, input logic [63:0] o);
    logic [REC_W-1:0] r;
    logic [7:0]  wp;
    logic [7:0]  rp;
    logic [15:0] v1;
    logic [15:0] v2;
    wp = gen_wptr(o);
    rp = gen_rptr(o);
    v1 = gen_vld1(o);
    v2 = gen_vld2(o);
    r = '0;
    r[95:80] = ts;
    r[79:48] = o[31:0];
    for (int c = 0; c < NUM_CH; c++)
      r[c*CH_W +: CH_W] = {wp[c*2 +: 2], rp[c*2 +: 2], v2[c*4 +: 4], v1[c*4 +: 4]};
    return r;
  endfunction

  // Records for orders lo..hi; ts counts from 0 at order 'first' (first cycle after arm).
  task automatic push_range(input int lo, input int hi, input int first);
    for (int o = lo; o <= hi; o++)
      exp_q.push_back({(o == hi), pack_rec(16'(o - first), 64'(o))});
  endtask

  // ---------------- monitor ----------------
  logic             prev_stall;
  logic [REC_W-1:0] prev_data;
  logic [REC_W:0]   mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 128'(rd_bus.rd_valid), 128'(1));
        check("stall_data", 128'(rd_bus.rd_data), 128'(prev_data));
      end
      if (rd_bus.rd_valid && rd_bus.rd_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pop: got %0h expected no record", rd_bus.rd_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_data", 128'(rd_bus.rd_data), 128'(mon_e[REC_W-1:0]));
          check("rd_last", 128'(rd_bus.rd_last), 128'(mon_e[REC_W]));
        end
      end
      prev_stall <= rd_bus.rd_valid && !rd_bus.rd_ready;
      prev_data  <= rd_bus.rd_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int s, input int e);
    cfg_start_order = 64'(s);
    cfg_end_order   = 64'(e);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic ramp(input int first, input int last);
    for (int o = first; o <= last; o++) begin
      mon_order = 64'(o);
      rvs_wptr  = gen_wptr(64'(o));
      rvs_rptr  = gen_rptr(64'(o));
      rvs_vld1  = gen_vld1(64'(o));
      rvs_vld2  = gen_vld2(64'(o));
      tick();
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (dbg_state != ST_IDLE && n < budget) begin
      tick();
      n++;
    end
    check(name, 128'(dbg_state), 128'(ST_IDLE));
  endtask

  task automatic wait_empty(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, 128'(exp_q.size()), 128'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] rdy_pat;

  initial begin
    rst_n = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    cfg_start_order = '0;
    cfg_end_order = '0;
    mon_order = '0;
    rvs_wptr = '0;
    rvs_rptr = '0;
    rvs_vld1 = '0;
    rvs_vld2 = '0;
    rd_bus.rd_ready = 1'b0;
    rdy_pat = 4'b1001;  // bit i drives rd_ready on cycle i: 1,0,0,1
    tick(); tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    check("rst_rd_valid", 128'(rd_bus.rd_valid), 128'(0));
    check("rst_rd_data", 128'(rd_bus.rd_data), 128'(0));
    check("rst_rd_last", 128'(rd_bus.rd_last), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_rec_count", 128'(rec_count), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(ST_IDLE));

    // Window 100..105 with a ramp 98..110: records 100..104.
    rd_bus.rd_ready = 1'b1;
    push_range(100, 104, 98);
    do_arm(100, 105);
    check("t1_armed", 128'(dbg_state), 128'(ST_ARMED));
    check("t1_busy", 128'(busy), 128'(1));
    ramp(98, 110);
    wait_idle(40, "t1_idle");
    wait_empty(5, "t1_all_popped");
    check("t1_overflow", 128'(overflow), 128'(0));
    check("t1_busy_end", 128'(busy), 128'(0));
    check("t1_rec_count", 128'(rec_count), 128'(0));

    // Empty window: start == end.
    mon_order = 64'd50;
    do_arm(50, 50);
    check("t2_armed", 128'(dbg_state), 128'(ST_ARMED));
    tick();
    check("t2_done", 128'(dbg_state), 128'(ST_DONE));
    check("t2_count", 128'(rec_count), 128'(0));
    tick();
    check("t2_idle", 128'(dbg_state), 128'(ST_IDLE));
    check("t2_rd_valid", 128'(rd_bus.rd_valid), 128'(0));

    // Stalled drain, rd_ready pattern 1,0,0,1 repeating.
    rd_bus.rd_ready = 1'b0;
    push_range(200, 203, 198);
    do_arm(200, 204);
    ramp(198, 205);
    check("t3_drain", 128'(dbg_state), 128'(ST_DRAIN));
    check("t3_count", 128'(rec_count), 128'(4));
    check("t3_valid", 128'(rd_bus.rd_valid), 128'(1));
    for (int i = 0; i < 40 && dbg_state != ST_IDLE; i++) begin
      rd_bus.rd_ready = rdy_pat[i % 4];
      tick();
    end
    check("t3_idle", 128'(dbg_state), 128'(ST_IDLE));
    wait_empty(2, "t3_all_popped");

    // Abort after three captured records.
    rd_bus.rd_ready = 1'b1;
    do_arm(300, 320);
    ramp(300, 302);
    check("t4_count_pre", 128'(rec_count), 128'(3));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_state", 128'(dbg_state), 128'(ST_IDLE));
    check("t4_count", 128'(rec_count), 128'(0));
    check("t4_rd_valid", 128'(rd_bus.rd_valid), 128'(0));
    check("t4_busy", 128'(busy), 128'(0));
    do_arm(300, 320);
    check("t4_rearm", 128'(dbg_state), 128'(ST_ARMED));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort2", 128'(dbg_state), 128'(ST_IDLE));

    // Overflow: window 0..40 into a 16-deep buffer.
    rd_bus.rd_ready = 1'b0;
`ifdef RVS_TRACE_WRAP_EN
    push_range(24, 39, 0);
`else
    push_range(0, 15, 0);
`endif
    do_arm(0, 40);
    ramp(0, 41);
    check("t5_state", 128'(dbg_state), 128'(ST_DRAIN));
    check("t5_overflow", 128'(overflow), 128'(1));
    check("t5_count", 128'(rec_count), 128'(16));
    rd_bus.rd_ready = 1'b1;
    tick(); tick(); tick();
    rd_bus.rd_ready = 1'b0;
    check("t5_count_after3", 128'(rec_count), 128'(13));

    // Asynchronous reset in the middle of the drain.
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rd_valid", 128'(rd_bus.rd_valid), 128'(0));
    check("t6_rd_data", 128'(rd_bus.rd_data), 128'(0));
    check("t6_rd_last", 128'(rd_bus.rd_last), 128'(0));
    check("t6_busy", 128'(busy), 128'(0));
    check("t6_overflow", 128'(overflow), 128'(0));
    check("t6_count", 128'(rec_count), 128'(0));
    check("t6_state", 128'(dbg_state), 128'(ST_IDLE));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Channel 2: wptr=3, rptr=1, vld2=0101, vld1=1010 -> record bits 35:24 = 0xD5A.
    rd_bus.rd_ready = 1'b1;
    rvs_wptr = 8'h30;
    rvs_rptr = 8'h10;
    rvs_vld1 = 16'h0A00;
    rvs_vld2 = 16'h0500;
    exp_q.push_back({1'b1, 16'h0000, 32'h0000_01F4, 48'h000D5A000000});
    do_arm(500, 501);
    mon_order = 64'd500;
    tick();
    mon_order = 64'd501;
    tick();
    for (int i = 0; i < 5 && !rd_bus.rd_valid; i++) tick();
    check("t7_valid", 128'(rd_bus.rd_valid), 128'(1));
    check("t7_ch2_slice", 128'(rd_bus.rd_data[35:24]), 128'(12'hD5A));
    wait_idle(10, "t7_idle");
    wait_empty(2, "t7_all_popped");
    check("t7_overflow", 128'(overflow), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
